adc_voltmeter: RTL and testbench
================================

# adc_voltmeter

Display-side stage downstream of `spi2adc`, replacing the fixed multiply and combinational BCD path. It consumes the 10-bit ADC sample stream (`data_from_adc` / `data_valid`) and averages a window of 2^LOG2_AVG samples. It scales the mean to millivolts and converts it to four BCD digits using a sequential double-dabble. The registered digits feed the `hex_to_7seg` decoders directly, with a one-cycle `update` strobe.

## Interface
- `LOG2_AVG`, 4: log2 of the averaging window; legal range 0..6.
- `SCALE`, 3300: full-scale millivolts. The product `1023*SCALE` must fit in 22 bits.
- `sysclk`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-high reset.
- `data_in`  in  10  ADC sample; sampled only when `data_valid` is high.
- `data_valid`  in  1  one-cycle strobe from `spi2adc`, marking a new sample.
- `bcd0`..`bcd3`  out  4 each  millivolt digits; `bcd0` = units, `bcd3` = thousands.
- `update`  out  1  one-cycle pulse; the digits changed on this cycle.
- `busy`  out  1  high while in SCALE or CONVERT.
- `overrun`  out  1  sticky; a window completed while `busy`. Cleared only by reset.

## Operation
- **Reset values:** all outputs 0, state ACCUM, accumulator 0, sample count 0.
- **Accumulator:**
  - Width 10+LOG2_AVG, unsigned.
  - Every `data_valid` adds `data_in` and increments the count, in every state. No sample is ever ignored.
- **Window completion:** occurs on the edge that samples the 2^LOG2_AVG-th sample.
  - `mean <= (acc + data_in) >> LOG2_AVG`, 10 bits, truncated.
  - Accumulator and count are cleared on the same edge.
  - If state is ACCUM: go to SCALE.
  - Otherwise: discard the mean, set `overrun`, and leave the conversion in progress untouched.
- **States:**
  - ACCUM: idle; waits for window completion.
  - SCALE: 1 cycle; `mv <= (mean*SCALE) >> 10`, 12 bits, truncated. Max value 3296 at the default SCALE.
  - CONVERT: 12 cycles of double-dabble on `mv`.
    - Each cycle: add 3 to every BCD nibble ≥ 5, then shift left by 1, bringing in the next `mv` bit MSB-first.
    - Uses a 4-bit shift counter.
  - UPDATE: 1 cycle; load `bcd0..3` from the shift register, pulse `update`, return to ACCUM.
- **Output hold:** `bcd0..3` change only in UPDATE. They hold their last value otherwise.
- **Reset mid-operation:** immediate return to reset values. A partial window or conversion is discarded, and no `update` is issued.

## Timing
- Let E0 be the edge that samples the final sample of a window.
  - SCALE occupies E0..E0+1.
  - CONVERT occupies edges E0+1..E0+13.
  - UPDATE occupies E0+13..E0+14.
  - Digits and `update` are registered at E0+14 and are visible on the next cycle.
- Latency from window completion to new digits: 14 cycles, fixed.
- `busy` is high from E0 to E0+13, i.e. 13 cycles.
- Minimum sustainable window spacing: 15 cycles. Closer spacing sets `overrun`.
- `data_valid` coinciding with UPDATE or SCALE is accumulated into the new window normally.

## Structure
- **Shared package `voltmeter_pkg`:**
  - constants ADC_W=10, MV_W=12, BCD_DIGITS=4;
  - state enum ACCUM/SCALE/CONVERT/UPDATE.
- **Sub-module `bin2bcd_seq`:** natural to split out.
  - Ports: start, 12-bit bin in; done, 16-bit bcd out.
  - Contains the 12-cycle shift/add-3 engine.
  - The top level keeps the accumulator, scaling multiply, FSM and output registers.

## Test plan
- Sixteen samples of 512, LOG2_AVG=4 → `update` at E0+14 with digits 1,6,5,0 (1650 mV); `overrun`=0.
- Sixteen samples of 1023 → digits 3,2,9,6; sixteen samples of 0 → digits 0,0,0,0, with `update` still pulsed.
- Alternating 0/1023 across 16 samples → sum 8184, mean 511, mv 1646 → digits 1,6,4,6.
- Reset asserted at E0+6, during CONVERT → all outputs 0 immediately, no `update`. The next full window converts correctly from a count of 0.
- LOG2_AVG=1 with `data_valid` high on every cycle:
  - first result delivered at E0+14;
  - `overrun`=1 from the second window onward;
  - samples arriving during `busy` are counted in later windows.

Source files
------------

// File: rtl/voltmeter_pkg.sv
// Shared constants and FSM state encoding for the ADC voltmeter display path.
package voltmeter_pkg;
  localparam int ADC_W      = 10;
  localparam int MV_W       = 12;
  localparam int BCD_DIGITS = 4;

  typedef enum logic [1:0] {
    S_ACCUM   = 2'd0,
    S_SCALE   = 2'd1,
    S_CONVERT = 2'd2,
    S_UPDATE  = 2'd3
  } state_t;
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: MV_W shift/add-3 steps, one per clock after start.
module bin2bcd_seq
  import voltmeter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MV_W-1:0]         bin,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);
  logic [MV_W-1:0]         sh;
  logic [3:0]              cnt;
  logic [4*BCD_DIGITS-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // done flags the edge that performs the final shift
  assign done = (cnt == 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh  <= '0;
      cnt <= '0;
      bcd <= '0;
    end else if (start) begin
      sh  <= bin;
      cnt <= 4'(MV_W);
      bcd <= '0;
    end else if (cnt != 4'd0) begin
      {bcd, sh} <= {adj, sh} << 1;
      cnt       <= cnt - 4'd1;
    end
  end
endmodule

// File: rtl/adc_voltmeter.sv
// Averages 2^LOG2_AVG ADC samples, scales to millivolts and emits BCD digits.
module adc_voltmeter
  import voltmeter_pkg::*;
#(
  parameter int LOG2_AVG = 4,
  parameter int SCALE    = 3300
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic [ADC_W-1:0] data_in,
  input  logic             data_valid,
  output logic [3:0]       bcd0,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd2,
  output logic [3:0]       bcd3,
  output logic             update,
  output logic             busy,
  output logic             overrun
);
  localparam int ACC_W = ADC_W + LOG2_AVG;
  localparam int CNT_W = LOG2_AVG + 1;
  localparam int PRD_W = ADC_W + MV_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << LOG2_AVG) - 1);

  state_t                  state;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        sum;
  logic [CNT_W-1:0]        cnt;
  logic [ADC_W-1:0]        mean;
  logic [PRD_W-1:0]        prod;
  logic [MV_W-1:0]         mv;
  logic                    win_done;
  logic                    conv_done;
  logic [4*BCD_DIGITS-1:0] bcd_w;

  assign sum      = acc + ACC_W'(data_in);
  assign win_done = data_valid && (cnt == LAST);
  assign prod     = PRD_W'(mean) * PRD_W'(SCALE);
  assign mv       = MV_W'(prod >> ADC_W);
  assign busy     = (state == S_SCALE) || (state == S_CONVERT);

  // mv is fed straight into the engine so loading coincides with SCALE
  bin2bcd_seq u_bcd (
    .clk   (sysclk),
    .rst   (reset),
    .start (state == S_SCALE),
    .bin   (mv),
    .done  (conv_done),
    .bcd   (bcd_w)
  );

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state   <= S_ACCUM;
      acc     <= '0;
      cnt     <= '0;
      mean    <= '0;
      bcd0    <= '0;
      bcd1    <= '0;
      bcd2    <= '0;
      bcd3    <= '0;
      update  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      update <= 1'b0;
      if (data_valid) begin
        if (win_done) begin
          acc <= '0;
          cnt <= '0;
          if (state == S_ACCUM)
            mean <= ADC_W'(sum >> LOG2_AVG);
          else
            overrun <= 1'b1;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
      unique case (state)
        S_ACCUM:   if (win_done) state <= S_SCALE;
        S_SCALE:   state <= S_CONVERT;
        S_CONVERT: if (conv_done) state <= S_UPDATE;
        S_UPDATE: begin
          bcd0   <= bcd_w[3:0];
          bcd1   <= bcd_w[7:4];
          bcd2   <= bcd_w[11:8];
          bcd3   <= bcd_w[15:12];
          update <= 1'b1;
          state  <= S_ACCUM;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adc_voltmeter.sv
// Directed table-driven bench for adc_voltmeter (LOG2_AVG=4 and LOG2_AVG=1).
module tb_adc_voltmeter;
  logic       sysclk;
  logic       reset;
  logic [9:0] data_in;
  logic       data_valid;
  logic [3:0] bcd0, bcd1, bcd2, bcd3;
  logic       update, busy, overrun;

  logic [9:0] d1_in;
  logic       d1_valid;
  logic [3:0] c0, c1, c2, c3;
  logic       update1, busy1, overrun1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [9:0] a;
    logic [9:0] b;
    bit         gap;
    logic [3:0] d3, d2, d1, d0;
    string      nm;
  } vec_t;

  vec_t vt[6];

  adc_voltmeter #(.LOG2_AVG(4), .SCALE(3300)) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .bcd0       (bcd0),
    .bcd1       (bcd1),
    .bcd2       (bcd2),
    .bcd3       (bcd3),
    .update     (update),
    .busy       (busy),
    .overrun    (overrun)
  );

  adc_voltmeter #(.LOG2_AVG(1), .SCALE(3300)) dut1 (
    .sysclk     (sysclk),
    .reset      (reset),
    .data_in    (d1_in),
    .data_valid (d1_valid),
    .bcd0       (c0),
    .bcd1       (c1),
    .bcd2       (c2),
    .bcd3       (c3),
    .update     (update1),
    .busy       (busy1),
    .overrun    (overrun1)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_digits(input string nm, input logic [3:0] e3, e2, e1, e0);
    chk({nm, ".d3"}, int'(bcd3), int'(e3));
    chk({nm, ".d2"}, int'(bcd2), int'(e2));
    chk({nm, ".d1"}, int'(bcd1), int'(e1));
    chk({nm, ".d0"}, int'(bcd0), int'(e0));
  endtask

  task automatic feed16(input logic [9:0] a, b, input bit gap);
    for (int i = 0; i < 16; i++) begin
      if (gap && i > 0) begin
        data_valid = 1'b0;
        data_in    = 10'h2AA;
        tick();
      end
      data_in    = i[0] ? b : a;
      data_valid = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    data_in    = 10'h155;
  endtask

  task automatic run_win(input vec_t v);
    int lat;
    int bcnt;
    feed16(v.a, v.b, v.gap);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    for (int n = 1; n <= 30 && lat == 0; n++) begin
      tick();
      if (update) lat = n;
      else if (busy) bcnt++;
    end
    chk({v.nm, ".latency"}, lat, 14);
    chk({v.nm, ".busy_cycles"}, bcnt, 13);
    chk_digits(v.nm, v.d3, v.d2, v.d1, v.d0);
    chk({v.nm, ".overrun"}, int'(overrun), 0);
    tick();
    chk({v.nm, ".update_pulse"}, int'(update), 0);
    chk({v.nm, ".hold_d0"}, int'(bcd0), int'(v.d0));
    repeat (3) tick();
  endtask

  initial begin
    int nupd;
    vt[0] = '{10'd512,  10'd512,  1'b0, 4'd1, 4'd6, 4'd5, 4'd0, "half"};
    vt[1] = '{10'd1023, 10'd1023, 1'b0, 4'd3, 4'd2, 4'd9, 4'd6, "full"};
    vt[2] = '{10'd0,    10'd0,    1'b0, 4'd0, 4'd0, 4'd0, 4'd0, "zero"};
    vt[3] = '{10'd0,    10'd1023, 1'b0, 4'd1, 4'd6, 4'd4, 4'd6, "alt"};
    vt[4] = '{10'd100,  10'd100,  1'b1, 4'd0, 4'd3, 4'd2, 4'd2, "gap100"};
    vt[5] = '{10'd1000, 10'd1000, 1'b1, 4'd3, 4'd2, 4'd2, 4'd2, "gap1000"};

    reset      = 1'b1;
    data_in    = '0;
    data_valid = 1'b0;
    d1_in      = '0;
    d1_valid   = 1'b0;
    tick();
    tick();
    chk("rst.digits", int'({bcd3, bcd2, bcd1, bcd0}), 0);
    chk("rst.update", int'(update), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.overrun", int'(overrun), 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_win(vt[i]);

    // LOG2_AVG=1, sample every cycle: edge k samples s_k, first window ends at k=1
    nupd = 0;
    for (int k = 0; k <= 40; k++) begin
      d1_in    = (k < 2) ? 10'd1023 : (k == 16) ? 10'd0 :
                 (k == 17) ? 10'd1023 : 10'd512;
      d1_valid = 1'b1;
      tick();
      if (k == 2) chk("l1.overrun_k2", int'(overrun1), 0);
      if (k == 3) chk("l1.overrun_k3", int'(overrun1), 1);
      if (update1) begin
        nupd++;
        if (nupd == 1) begin
          chk("l1.first_edge", k, 15);
          chk("l1.first_val", int'({c3, c2, c1, c0}), 16'h3296);
        end else if (nupd == 2) begin
          chk("l1.second_edge", k, 31);
          chk("l1.second_val", int'({c3, c2, c1, c0}), 16'h1646);
        end
      end
    end
    d1_valid = 1'b0;
    chk("l1.updates", nupd, 2);
    chk("l1.overrun_sticky", int'(overrun1), 1);

    // reset in the middle of CONVERT
    feed16(10'd1023, 10'd1023, 1'b0);
    repeat (6) tick();
    chk("mid.busy_before", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("mid.digits", int'({bcd3, bcd2, bcd1, bcd0}), 0);
    chk("mid.busy", int'(busy), 0);
    chk("mid.update", int'(update), 0);
    chk("mid.overrun1_cleared", int'(overrun1), 0);
    tick();
    reset = 1'b0;
    nupd  = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (update) nupd++;
    end
    chk("mid.no_update", nupd, 0);
    chk("mid.digits_after", int'({bcd3, bcd2, bcd1, bcd0}), 0);

    run_win('{10'd512, 10'd512, 1'b0, 4'd1, 4'd6, 4'd5, 4'd0, "post_rst"});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
